// File: rtl/mc_delay_pkg.sv
// Shared types and default constants for the delay-line calibration controller.
package mc_delay_pkg;

    localparam int unsigned DEF_DELAY_WIDTH   = 4;
    localparam int unsigned DEF_SETTLE_CYCLES = 8;
    localparam int unsigned DEF_SAMPLE_COUNT  = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        SAMPLE = 3'd2,
        EVAL   = 3'd3,
        DONE   = 3'd4
    } calib_state_e;

endpackage

// File: rtl/mc_delay_sample_filter.sv
// Majority-free sample filter: counts ones over SampleCount enabled cycles and
// reports whether the window was all ones, all zeros, and complete.
module mc_delay_sample_filter #(
    parameter int unsigned SampleCount = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    input  logic sample_i,
    output logic all_one_o,
    output logic all_zero_o,
    output logic valid_o
);

    localparam int unsigned CW = $clog2(SampleCount) + 1;
    localparam logic [CW-1:0] FULL = CW'(SampleCount);

    logic [CW-1:0] taken_q, taken_d;
    logic [CW-1:0] ones_q, ones_d;
    logic          valid_q, valid_d;
    logic          all_one_q, all_one_d;
    logic          all_zero_q, all_zero_d;

    // Next-state for the window counters and the registered classification flags.
    always_comb begin
        taken_d = taken_q;
        ones_d  = ones_q;
        if (clr_i) begin
            taken_d = {CW{1'b0}};
            ones_d  = {CW{1'b0}};
        end else if (en_i && (taken_q != FULL)) begin
            taken_d = taken_q + CW'(1'b1);
            ones_d  = ones_q + CW'(sample_i);
        end else begin
            taken_d = taken_q;
            ones_d  = ones_q;
        end
        valid_d    = (taken_d == FULL);
        all_one_d  = (taken_d == FULL) && (ones_d == FULL);
        all_zero_d = (taken_d == FULL) && (ones_d == {CW{1'b0}});
    end

    // Window counter and flag registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            taken_q    <= {CW{1'b0}};
            ones_q     <= {CW{1'b0}};
            valid_q    <= 1'b0;
            all_one_q  <= 1'b0;
            all_zero_q <= 1'b0;
        end else begin
            taken_q    <= taken_d;
            ones_q     <= ones_d;
            valid_q    <= valid_d;
            all_one_q  <= all_one_d;
            all_zero_q <= all_zero_d;
        end
    end

    assign all_one_o  = all_one_q;
    assign all_zero_o = all_zero_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/mc_delay_calib.sv
// Delay-line calibration controller: sweeps the delay code upward from 0,
// settles, samples the synchronized phase bit and locks on the first flip.
// Also muxes a manual override code and exposes lock/error status.
module mc_delay_calib
    import mc_delay_pkg::*;
#(
    parameter int unsigned DelayWidth   = DEF_DELAY_WIDTH,
    parameter int unsigned SettleCycles = DEF_SETTLE_CYCLES,
    parameter int unsigned SampleCount  = DEF_SAMPLE_COUNT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  manual_en_i,
    input  logic [DelayWidth-1:0] manual_delay_i,
    input  logic                  sample_i,
    output logic [DelayWidth-1:0] delay_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  locked_o,
    output logic                  error_o,
    output logic [DelayWidth-1:0] lock_code_o
);

    localparam int unsigned SCW = $clog2(SettleCycles) + 1;
    localparam int unsigned NCW = $clog2(SampleCount) + 1;
    localparam logic [SCW-1:0]        SETTLE_LAST = SCW'(SettleCycles - 1);
    localparam logic [NCW-1:0]        SAMPLE_LAST = NCW'(SampleCount - 1);
    localparam logic [DelayWidth-1:0] CODE_MAX    = {DelayWidth{1'b1}};
    localparam logic [DelayWidth-1:0] CODE_ZERO   = {DelayWidth{1'b0}};

    calib_state_e          state_q, state_d;
    logic [DelayWidth-1:0] code_q, code_d;
    logic [SCW-1:0]        settle_cnt_q, settle_cnt_d;
    logic [NCW-1:0]        samp_cnt_q, samp_cnt_d;
    logic                  ref_q, ref_d;
    logic                  locked_q, locked_d;
    logic                  error_q, error_d;
    logic [DelayWidth-1:0] lock_code_q, lock_code_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic [DelayWidth-1:0] delay_q, delay_d;

    logic filt_clr_s;
    logic filt_en_s;
    logic filt_all_one_s;
    logic filt_all_zero_s;
    logic filt_valid_s;
    logic stable_s;

    // The filter window is cleared for the whole settle phase so every code
    // starts with a fresh count; only SAMPLE cycles feed it.
    assign filt_clr_s = (state_q == SETTLE);
    assign filt_en_s  = (state_q == SAMPLE);

    mc_delay_sample_filter #(
        .SampleCount(SampleCount)
    ) u_filter (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (filt_clr_s),
        .en_i      (filt_en_s),
        .sample_i  (sample_i),
        .all_one_o (filt_all_one_s),
        .all_zero_o(filt_all_zero_s),
        .valid_o   (filt_valid_s)
    );

    // An incomplete window is treated like an unstable one.
    assign stable_s = filt_valid_s && (filt_all_one_s || filt_all_zero_s);

    // Sweep FSM next-state, status updates and the registered-output next values.
    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        settle_cnt_d = settle_cnt_q;
        samp_cnt_d   = samp_cnt_q;
        ref_d        = ref_q;
        locked_d     = locked_q;
        error_d      = error_q;
        lock_code_d  = lock_code_q;
        delay_d      = CODE_ZERO;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d      = SETTLE;
                    code_d       = CODE_ZERO;
                    locked_d     = 1'b0;
                    error_d      = 1'b0;
                    settle_cnt_d = {SCW{1'b0}};
                    samp_cnt_d   = {NCW{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d    = SAMPLE;
                    samp_cnt_d = {NCW{1'b0}};
                end else begin
                    settle_cnt_d = settle_cnt_q + SCW'(1'b1);
                end
            end
            SAMPLE: begin
                if (samp_cnt_q == SAMPLE_LAST) begin
                    state_d = EVAL;
                end else begin
                    samp_cnt_d = samp_cnt_q + NCW'(1'b1);
                end
            end
            EVAL: begin
                if (code_q == CODE_ZERO) begin
                    if (!stable_s) begin
                        error_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        ref_d        = filt_all_one_s;
                        code_d       = code_q + DelayWidth'(1'b1);
                        settle_cnt_d = {SCW{1'b0}};
                        state_d      = SETTLE;
                    end
                end else if (!stable_s || (filt_all_one_s != ref_q)) begin
                    lock_code_d = code_q;
                    locked_d    = 1'b1;
                    state_d     = DONE;
                end else if (code_q == CODE_MAX) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end else begin
                    code_d       = code_q + DelayWidth'(1'b1);
                    settle_cnt_d = {SCW{1'b0}};
                    state_d      = SETTLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);

        if (busy_d) begin
            delay_d = code_d;
        end else if (manual_en_i) begin
            delay_d = manual_delay_i;
        end else if (locked_d) begin
            delay_d = lock_code_d;
        end else begin
            delay_d = CODE_ZERO;
        end
    end

    // State, sweep bookkeeping and registered outputs; reset returns everything
    // to idle with no done pulse, the delay mux still honouring manual override.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            code_q       <= CODE_ZERO;
            settle_cnt_q <= {SCW{1'b0}};
            samp_cnt_q   <= {NCW{1'b0}};
            ref_q        <= 1'b0;
            locked_q     <= 1'b0;
            error_q      <= 1'b0;
            lock_code_q  <= CODE_ZERO;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            delay_q      <= manual_en_i ? manual_delay_i : CODE_ZERO;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            settle_cnt_q <= settle_cnt_d;
            samp_cnt_q   <= samp_cnt_d;
            ref_q        <= ref_d;
            locked_q     <= locked_d;
            error_q      <= error_d;
            lock_code_q  <= lock_code_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            delay_q      <= delay_d;
        end
    end

    assign delay_o     = delay_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign locked_o    = locked_q;
    assign error_o     = error_q;
    assign lock_code_o = lock_code_q;

endmodule

// File: tb/tb_mc_delay_calib.sv
// Directed testbench for mc_delay_calib with default parameters
// (DelayWidth=4, SettleCycles=8, SampleCount=4, per-code period 13).
module tb_mc_delay_calib;
    import mc_delay_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic       manual_en_i;
    logic [3:0] manual_delay_i;
    logic       sample_i;
    logic [3:0] delay_o;
    logic       busy_o;
    logic       done_o;
    logic       locked_o;
    logic       error_o;
    logic [3:0] lock_code_o;

    int checks = 0;
    int errors = 0;
    int done_at;
    int done_pulses;

    mc_delay_calib dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .manual_en_i   (manual_en_i),
        .manual_delay_i(manual_delay_i),
        .sample_i      (sample_i),
        .delay_o       (delay_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .locked_o      (locked_o),
        .error_o       (error_o),
        .lock_code_o   (lock_code_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Start a sweep and watch it for a fixed window. Cycle 1 is the first
    // cycle after the edge that samples start_i.
    // mode 1: sample = delay>=5 (plus ignored start/manual pokes while busy)
    // mode 2: sample constant 1
    // mode 3: sample toggles every cycle
    // mode 4: zeros, except ones during code-1 SETTLE (ignored) and one 1 in code-3 SAMPLE
    task automatic run_sweep(input int mode, output int first_done, output int pulses);
        first_done = 0;
        pulses     = 0;
        start_i    = 1'b1;
        step();
        start_i = 1'b0;
        check("busy_after_start", 32'(busy_o), 32'd1);
        for (int cyc = 1; cyc <= 230; cyc++) begin
            if (done_o) begin
                pulses++;
                if (first_done == 0) first_done = cyc;
            end
            if (mode == 1 && cyc <= 78)
                check("sweep_delay", 32'(delay_o), 32'((cyc - 1) / 13));
            case (mode)
                1: sample_i = (delay_o >= 4'd5);
                2: sample_i = 1'b1;
                3: sample_i = cyc[0];
                4: sample_i = (cyc == 49) || (cyc >= 14 && cyc <= 21);
                default: sample_i = 1'b0;
            endcase
            if (mode == 1) begin
                start_i        = (cyc == 30);
                manual_en_i    = (cyc == 30) || (cyc == 31);
                manual_delay_i = 4'd9;
            end
            step();
        end
        sample_i    = 1'b0;
        start_i     = 1'b0;
        manual_en_i = 1'b0;
    endtask

    initial begin
        rst_i          = 1'b1;
        start_i        = 1'b0;
        manual_en_i    = 1'b1;
        manual_delay_i = 4'd9;
        sample_i       = 1'b0;
        @(negedge clk_i);
        step();
        step();

        // Reset state (manual override still drives the delay mux)
        check("rst_delay_manual", 32'(delay_o), 32'd9);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_locked", 32'(locked_o), 32'd0);
        check("rst_error", 32'(error_o), 32'd0);
        check("rst_lock_code", 32'(lock_code_o), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        manual_en_i = 1'b0;
        step();
        check("rst_delay_zero", 32'(delay_o), 32'd0);
        rst_i = 1'b0;
        step();

        // Lock at code 5; start/manual while busy ignored
        run_sweep(1, done_at, done_pulses);
        check("t1_done_cycle", 32'(done_at), 32'd79);
        check("t1_done_pulses", 32'(done_pulses), 32'd1);
        check("t1_locked", 32'(locked_o), 32'd1);
        check("t1_lock_code", 32'(lock_code_o), 32'd5);
        check("t1_error", 32'(error_o), 32'd0);
        check("t1_delay", 32'(delay_o), 32'd5);
        check("t1_busy", 32'(busy_o), 32'd0);

        // Manual override after lock
        manual_en_i    = 1'b1;
        manual_delay_i = 4'd9;
        step();
        check("man_delay_9", 32'(delay_o), 32'd9);
        manual_en_i = 1'b0;
        step();
        check("man_delay_back", 32'(delay_o), 32'd5);

        // Constant 1: no flip up to code 15 -> error, lock code kept
        run_sweep(2, done_at, done_pulses);
        check("t2_done_cycle", 32'(done_at), 32'd209);
        check("t2_done_pulses", 32'(done_pulses), 32'd1);
        check("t2_error", 32'(error_o), 32'd1);
        check("t2_locked", 32'(locked_o), 32'd0);
        check("t2_lock_code_kept", 32'(lock_code_o), 32'd5);
        check("t2_delay", 32'(delay_o), 32'd0);

        // Toggling sample at code 0 -> immediate error
        run_sweep(3, done_at, done_pulses);
        check("t3_done_cycle", 32'(done_at), 32'd14);
        check("t3_done_pulses", 32'(done_pulses), 32'd1);
        check("t3_error", 32'(error_o), 32'd1);
        check("t3_locked", 32'(locked_o), 32'd0);
        check("t3_delay", 32'(delay_o), 32'd0);

        // One 1 among four at code 3 -> unstable -> lock at 3
        run_sweep(4, done_at, done_pulses);
        check("t6_done_cycle", 32'(done_at), 32'd53);
        check("t6_done_pulses", 32'(done_pulses), 32'd1);
        check("t6_locked", 32'(locked_o), 32'd1);
        check("t6_lock_code", 32'(lock_code_o), 32'd3);
        check("t6_error", 32'(error_o), 32'd0);
        check("t6_delay", 32'(delay_o), 32'd3);

        // Reset at cycle 30 of a sweep
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int c = 1; c < 30; c++) step();
        check("t5_busy_before", 32'(busy_o), 32'd1);
        check("t5_delay_before", 32'(delay_o), 32'd2);
        rst_i = 1'b1;
        step();
        check("t5_delay", 32'(delay_o), 32'd0);
        check("t5_busy", 32'(busy_o), 32'd0);
        check("t5_done", 32'(done_o), 32'd0);
        check("t5_locked", 32'(locked_o), 32'd0);
        check("t5_error", 32'(error_o), 32'd0);
        check("t5_lock_code", 32'(lock_code_o), 32'd0);
        check("t5_state", 32'(dut.state_q), 32'(IDLE));
        rst_i       = 1'b0;
        done_pulses = 0;
        for (int c = 0; c < 60; c++) begin
            if (done_o) done_pulses++;
            step();
        end
        check("t5_no_done", 32'(done_pulses), 32'd0);
        check("t5_idle_busy", 32'(busy_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
